pushbutton_conditioner: RTL and testbench



---
 rtl/pushbutton_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_pushbutton_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_conditioner.sv
// -----------------------------------------------------------------------------
// pushbutton_conditioner
//
// Turns the raw, active-low, bouncing DE1-SoC KEY pins into a clean level bus
// for the pushbuttons_export PIO. Each key has its own two-flop synchroniser, a
// four-state debounce FSM, one-cycle press/release strobes, and a sticky event
// bit that software clears with a strobe. Everything runs on clk
// (system_ref_clk).
//
// Optional feature macro: PUSHBUTTON_REPEAT_EN
//   When defined, a key held in the pressed state re-fires key_press after
//   REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles while held.
//   When undefined there is no repeat logic and key_press fires once per press.
//
// Parameters:
//   NUM_KEYS        number of keys; width of every per-key bus
//   DEBOUNCE_CYCLES cycles the synchronised key must stay stable (>= 2)
//   REPEAT_DELAY    hold cycles before the first auto-repeat pulse
//   REPEAT_PERIOD   cycles between later auto-repeat pulses (<= REPEAT_DELAY)
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active-high
//   key_n       in   raw keys, 0 = pressed, asynchronous and bouncing
//   evt_clear   in   per-bit strobe clearing the matching evt_sticky bit
//   key_level   out  debounced level, 1 = pressed
//   key_press   out  one-cycle pulse on an accepted press (and each repeat)
//   key_release out  one-cycle pulse on an accepted release
//   evt_sticky  out  set by key_press, held until evt_clear
// -----------------------------------------------------------------------------
module pushbutton_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] evt_clear,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] evt_sticky
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef PUSHBUTTON_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes the next terminal count PERIOD cycles away.
  localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

  // The counters cannot represent these settings, so stop at elaboration.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_invalid_params
    $error("pushbutton_conditioner: invalid debounce/repeat parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;

  // Two plain flops per key with nothing between them; reset to the
  // released level so no phantom press appears out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             s;
`ifdef PUSHBUTTON_REPEAT_EN
    logic [RCNT_W-1:0] rcnt;
`endif

    // Synchronised key, 1 = pressed.
    assign s = ~sync2[i];

    // Debounce FSM. A level change is accepted only after s has held the new
    // value for DEBOUNCE_CYCLES consecutive cycles; any return to the old
    // value during the wait abandons it without a pulse. Pulses default low
    // every cycle, so each is exactly one cycle wide.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef PUSHBUTTON_REPEAT_EN
        rcnt      <= '0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          IDLE: begin
            if (s) begin
              cnt   <= '0;
              state <= PRESS_WAIT;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (cnt == CNT_LAST) begin
              level_q <= 1'b1;
              press_q <= 1'b1;
              state   <= PRESSED;
`ifdef PUSHBUTTON_REPEAT_EN
              rcnt    <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PRESSED: begin
            if (!s) begin
              // rcnt is left alone so a bounce back to PRESSED resumes it.
              cnt   <= '0;
              state <= RELEASE_WAIT;
            end
`ifdef PUSHBUTTON_REPEAT_EN
            else if (rcnt == RCNT_LAST) begin
              press_q <= 1'b1;
              rcnt    <= RCNT_RELOAD;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
`endif
          end
          RELEASE_WAIT: begin
            if (s) begin
              state <= PRESSED;
            end else if (cnt == CNT_LAST) begin
              level_q   <= 1'b0;
              release_q <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

  // Sticky events are set from the registered press strobe, so a clear that
  // lands in the same cycle as key_press loses to the set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_sticky <= '0;
    end else begin
      evt_sticky <= (evt_sticky & ~evt_clear) | key_press;
    end
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pushbutton_conditioner
//
// Directed bench for pushbutton_conditioner with DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=20, REPEAT_PERIOD=5. Expected press/release pulses are queued
// with their due cycle when the stimulus is driven; a monitor pops and compares
// every pulse the DUT emits. Level and sticky values are checked inline.
// Honours PUSHBUTTON_REPEAT_EN for the auto-repeat expectations.
// -----------------------------------------------------------------------------
module tb_pushbutton_conditioner;

  localparam int NK  = 3;
  localparam int DB  = 8;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int LAT = DB + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] evt_clear;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] evt_sticky;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int cycle;
    int key;
    int kind;
  } pulse_t;

  pulse_t expq[$];

  pushbutton_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .evt_clear  (evt_clear),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .evt_sticky (evt_sticky)
  );

  // 10 ns clock; cyc counts rising edges so pulse due times are edge numbers.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cyc);
      $error("[TB] %s miscompare", tag);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] kn, input logic [NK-1:0] clr);
    key_n     = kn;
    evt_clear = clr;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind 0 = press, 1 = release
  task automatic expectPulse(input int at, input int key, input int kind);
    pulse_t e;
    e.cycle = at;
    e.key   = key;
    e.kind  = kind;
    expq.push_back(e);
  endtask

  // Scoreboard monitor: every strobe seen must match the oldest queued one.
  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && key_press[i]) || (k == 1 && key_release[i])) begin
          checkOutput("pulse_expected", 32'(expq.size() > 0), 32'd1);
          if (expq.size() > 0) begin
            pulse_t e;
            e = expq.pop_front();
            checkOutput("pulse_cycle_key_kind",
                        {cyc[15:0], 8'(i), 8'(k)},
                        {e.cycle[15:0], 8'(e.key), 8'(e.kind)});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    int p;

    reset = 1'b1;
    applyStimulus(3'b111, 3'b000);
    waitCycles(3);
    checkOutput("rst_level",   32'(key_level),   32'd0);
    checkOutput("rst_press",   32'(key_press),   32'd0);
    checkOutput("rst_release", 32'(key_release), 32'd0);
    checkOutput("rst_sticky",  32'(evt_sticky),  32'd0);
    reset = 1'b0;
    waitCycles(4);

    // Clean press on key 0, then release.
    t = cyc;
    applyStimulus(3'b110, 3'b000);
    expectPulse(t + LAT, 0, 0);
    waitCycles(LAT - 1);
    checkOutput("clean_level_early", 32'(key_level), 32'd0);
    waitCycles(2);
    checkOutput("clean_level", 32'(key_level), 32'b001);
    checkOutput("clean_sticky", 32'(evt_sticky), 32'b001);
    t = cyc;
    applyStimulus(3'b111, 3'b000);
    expectPulse(t + LAT, 0, 1);
    waitCycles(LAT + 1);
    checkOutput("clean_release_level", 32'(key_level), 32'd0);
    checkOutput("sticky_survives_release", 32'(evt_sticky), 32'b001);

    // Lone clear, then clear of an already-clear bit.
    applyStimulus(3'b111, 3'b001);
    waitCycles(1);
    applyStimulus(3'b111, 3'b000);
    checkOutput("lone_clear", 32'(evt_sticky), 32'd0);
    applyStimulus(3'b111, 3'b001);
    waitCycles(1);
    applyStimulus(3'b111, 3'b000);
    checkOutput("clear_when_zero", 32'(evt_sticky), 32'd0);

    // Set/clear collision on key 0.
    t = cyc;
    applyStimulus(3'b110, 3'b000);
    expectPulse(t + LAT, 0, 0);
    waitCycles(LAT);
    checkOutput("collision_press_live", 32'(key_press), 32'b001);
    checkOutput("collision_sticky_before", 32'(evt_sticky), 32'd0);
    applyStimulus(3'b110, 3'b001);
    waitCycles(1);
    checkOutput("collision_set_wins", 32'(evt_sticky), 32'b001);
    t = cyc;
    applyStimulus(3'b111, 3'b001);
    expectPulse(t + LAT, 0, 1);
    waitCycles(1);
    applyStimulus(3'b111, 3'b000);
    checkOutput("collision_then_clear", 32'(evt_sticky), 32'd0);
    waitCycles(LAT);
    checkOutput("collision_release_level", 32'(key_level), 32'd0);

    // Bounce rejection on key 1.
    applyStimulus(3'b101, 3'b000);
    waitCycles(5);
    applyStimulus(3'b111, 3'b000);
    waitCycles(2);
    t = cyc;
    applyStimulus(3'b101, 3'b000);
    expectPulse(t + LAT, 1, 0);
    waitCycles(LAT - 1);
    checkOutput("bounce_level_early", 32'(key_level), 32'd0);
    waitCycles(2);
    checkOutput("bounce_level", 32'(key_level), 32'b010);
    checkOutput("bounce_sticky", 32'(evt_sticky), 32'b010);
    t = cyc;
    applyStimulus(3'b111, 3'b000);
    expectPulse(t + LAT, 1, 1);
    waitCycles(LAT + 1);
    checkOutput("bounce_release_level", 32'(key_level), 32'd0);

    // Release glitch on key 2.
    t = cyc;
    applyStimulus(3'b011, 3'b000);
    expectPulse(t + LAT, 2, 0);
    waitCycles(LAT + 1);
    applyStimulus(3'b111, 3'b000);
    waitCycles(3);
    applyStimulus(3'b011, 3'b000);
    waitCycles(5);
    checkOutput("glitch_level_held", 32'(key_level), 32'b100);
    t = cyc;
    applyStimulus(3'b111, 3'b000);
    expectPulse(t + LAT, 2, 1);
    waitCycles(LAT + 1);
    checkOutput("glitch_release_level", 32'(key_level), 32'd0);
    checkOutput("sticky_keys_1_2", 32'(evt_sticky), 32'b110);

    // Reset during PRESS_WAIT with key 0 held.
    applyStimulus(3'b110, 3'b000);
    waitCycles(6);
    reset = 1'b1;
    #1;
    checkOutput("midrst_level",   32'(key_level),   32'd0);
    checkOutput("midrst_press",   32'(key_press),   32'd0);
    checkOutput("midrst_release", 32'(key_release), 32'd0);
    checkOutput("midrst_sticky",  32'(evt_sticky),  32'd0);
    waitCycles(2);
    reset = 1'b0;
    t = cyc;
    p = t + LAT;
    expectPulse(p, 0, 0);
    waitCycles(LAT + 1);
    checkOutput("postrst_level", 32'(key_level), 32'b001);
    checkOutput("postrst_sticky", 32'(evt_sticky), 32'b001);

    // Key 0 held 40 cycles past the press.
`ifdef PUSHBUTTON_REPEAT_EN
    expectPulse(p + RD, 0, 0);
    expectPulse(p + RD + RP, 0, 0);
    expectPulse(p + RD + 2 * RP, 0, 0);
    expectPulse(p + RD + 3 * RP, 0, 0);
    expectPulse(p + RD + 4 * RP, 0, 0);
`endif
    waitCycles(39);
    checkOutput("hold_level", 32'(key_level), 32'b001);
    t = cyc;
    applyStimulus(3'b111, 3'b000);
    expectPulse(t + LAT, 0, 1);
    waitCycles(LAT + 1);
    checkOutput("hold_release_level", 32'(key_level), 32'd0);

    waitCycles(2);
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
